// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic.
package uart_pkg;

  // Arbiter FSM states; the encoding is fixed so that external tools see stable values.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2
  } arb_state_e;

  // Default channel-ID header base; the port number is OR-ed into the low bits.
  localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first requesting index strictly after i_last, wrapping at N.
module rr_select
  import uart_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  logic [IDW-1:0] w_pos;

  // Walk the candidates last+1 .. last+N (mod N) and keep the first one requesting.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_pos = IDW'((32'(i_last) + k) % N);
      if (!o_found && i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding a single UART transmitter.
// A grant lasts from arbitration until the tlast beat of the granted port;
// optionally a channel-ID header byte precedes each packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned           PORTS       = 4,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter bit                    HEADER_EN   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] HEADER_BASE = DATA_WIDTH'(HEADER_BASE_DEFAULT),
  parameter int unsigned           IDW         = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] w_grant_nxt;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_last_nxt;

  logic           w_found;
  logic [IDW-1:0] w_idx;

  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [PORTS-1:0]      w_sel_oh;
  logic                  w_xfer;

  rr_select #(
    .N   (PORTS),
    .IDW (IDW)
  ) u_rr_select (
    .i_req   (s_axis_tvalid),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Route the granted port's stream signals and build its one-hot select.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_oh    = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (IDW'(p) == r_grant) begin
        w_sel_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        w_sel_valid = s_axis_tvalid[p];
        w_sel_last  = s_axis_tlast[p];
        w_sel_oh[p] = 1'b1;
      end
    end
  end

  // State, grant and round-robin pointer registers; last starts at PORTS-1 so port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IDW'(PORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic and the outputs seen by the UART and the sources.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    w_xfer        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_idx;
          w_last_nxt  = w_idx;
          w_state_nxt = HEADER_EN ? S_HEADER : S_DATA;
        end
      end
      S_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = HEADER_BASE | DATA_WIDTH'(r_grant);
        if (m_axis_tready) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        m_axis_tvalid = w_sel_valid;
        m_axis_tdata  = w_sel_data;
        s_axis_tready = w_sel_oh & {PORTS{m_axis_tready}};
        w_xfer        = w_sel_valid & m_axis_tready;
        if (w_xfer && w_sel_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (header-enabled and header-less instances).
module tb_uart_tx_arbiter;

  localparam int PORTS   = 4;
  localparam int DW      = 8;
  localparam int TOG_LOW = 20;

  logic              clk;
  logic              rst;
  logic [PORTS*DW-1:0] s_data;
  logic [PORTS-1:0]  s_valid;
  logic [PORTS-1:0]  s_last;
  logic [PORTS-1:0]  s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        grant;
  logic              busy;

  logic [PORTS*DW-1:0] nh_s_data;
  logic [PORTS-1:0]  nh_s_valid;
  logic [PORTS-1:0]  nh_s_last;
  logic [PORTS-1:0]  nh_s_ready;
  logic [DW-1:0]     nh_m_data;
  logic              nh_m_valid;
  logic              nh_m_ready;
  logic [1:0]        nh_grant;
  logic              nh_busy;

  uart_tx_arbiter #(
    .PORTS       (PORTS),
    .DATA_WIDTH  (DW),
    .HEADER_EN   (1'b1),
    .HEADER_BASE (8'hA0)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .grant_id      (grant),
    .busy          (busy)
  );

  uart_tx_arbiter #(
    .PORTS      (PORTS),
    .DATA_WIDTH (DW),
    .HEADER_EN  (1'b0)
  ) u_dut_nh (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (nh_s_data),
    .s_axis_tvalid (nh_s_valid),
    .s_axis_tlast  (nh_s_last),
    .s_axis_tready (nh_s_ready),
    .m_axis_tdata  (nh_m_data),
    .m_axis_tvalid (nh_m_valid),
    .m_axis_tready (nh_m_ready),
    .grant_id      (nh_grant),
    .busy          (nh_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [8:0]      src_q [PORTS][$];
  logic [DW-1:0]   exp_q [$];
  logic [PORTS-1:0] stall;
  logic [PORTS-1:0] hs;
  bit              tog_mode;
  int              tog_cnt;
  bit              prev_busy;
  int              idle_cnt;
  int              last_gap;
  bit              saw_p0_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic beat(input int p, input logic [7:0] d, input bit lst);
    src_q[p].push_back({lst, d});
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back(d);
  endtask

  // Present each source queue head unless the port is stalled.
  task automatic drive_src();
    logic [8:0] h;
    for (int p = 0; p < PORTS; p++) begin
      if (src_q[p].size() > 0 && !stall[p]) begin
        h = src_q[p][0];
        s_valid[p]        = 1'b1;
        s_last[p]         = h[8];
        s_data[p*DW +: DW] = h[7:0];
      end else begin
        s_valid[p]        = 1'b0;
        s_last[p]         = 1'b0;
        s_data[p*DW +: DW] = '0;
      end
    end
  endtask

  // One clock: monitor at negedge, then advance sources and downstream ready after posedge.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'(m_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("beat", 32'(m_data), 32'(e));
      end
    end
    chk("ready_onehot0", 32'($onehot0(s_ready)), 32'(1));
    chk("ready_without_xfer", 32'(s_ready & s_valid & ~{PORTS{m_valid & m_ready}}), 32'(0));
    if (s_ready[0]) saw_p0_ready = 1'b1;
    if (busy) begin
      if (!prev_busy) last_gap = idle_cnt;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    prev_busy = busy;
    hs = s_valid & s_ready & {PORTS{~rst}};
    @(posedge clk);
    #1;
    for (int p = 0; p < PORTS; p++) begin
      if (hs[p]) void'(src_q[p].pop_front());
    end
    if (tog_mode) begin
      tog_cnt = (tog_cnt >= TOG_LOW) ? 0 : tog_cnt + 1;
      m_ready = (tog_cnt == 0);
    end else begin
      m_ready = 1'b1;
    end
    drive_src();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size() == 0 && !busy), 32'(1));
  endtask

  task automatic wait_exp_left(input string tag, input int left, input int budget);
    int n = 0;
    while (exp_q.size() > left && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'(left));
  endtask

  initial begin
    rst = 1'b1;
    m_ready = 1'b1;
    s_data = '0; s_valid = '0; s_last = '0;
    nh_s_data = '0; nh_s_valid = '0; nh_s_last = '0; nh_m_ready = 1'b1;
    stall = '0; hs = '0;
    tog_mode = 1'b0; tog_cnt = 0;
    prev_busy = 1'b0; idle_cnt = 0; last_gap = -1; saw_p0_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_s_ready", 32'(s_ready), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_nh_valid", 32'(nh_m_valid), 32'(0));

    // 1: port 0, three beats, ready held high
    beat(0, 8'h11, 0); beat(0, 8'h22, 0); beat(0, 8'h33, 1);
    expect_byte(8'hA0); expect_byte(8'h11); expect_byte(8'h22); expect_byte(8'h33);
    drive_src();
    wait_done("t1_done", 50);
    chk("t1_grant_hold", 32'(grant), 32'(0));

    // 2: make port 1 the last served, then ports 1 and 2 together
    beat(1, 8'h44, 1);
    expect_byte(8'hA1); expect_byte(8'h44);
    drive_src();
    wait_done("t2a_done", 50);
    beat(1, 8'h55, 1);
    beat(2, 8'h66, 0); beat(2, 8'h77, 1);
    expect_byte(8'hA2); expect_byte(8'h66); expect_byte(8'h77);
    expect_byte(8'hA1); expect_byte(8'h55);
    drive_src();
    wait_done("t2b_done", 80);
    chk("t2_gap", 32'(last_gap), 32'(1));
    chk("t2_grant_hold", 32'(grant), 32'(1));

    // 3: UART-like ready pacing on port 3
    tog_mode = 1'b1; tog_cnt = 0; m_ready = 1'b1;
    beat(3, 8'h31, 0); beat(3, 8'h32, 0); beat(3, 8'h33, 0); beat(3, 8'h34, 1);
    expect_byte(8'hA3); expect_byte(8'h31); expect_byte(8'h32);
    expect_byte(8'h33); expect_byte(8'h34);
    drive_src();
    wait_done("t3_done", 400);
    chk("t3_src_drained", 32'(src_q[3].size()), 32'(0));
    tog_mode = 1'b0; m_ready = 1'b1;

    // 4: port 3 stalls mid-packet while port 0 requests
    beat(3, 8'h41, 0); beat(3, 8'h42, 0); beat(3, 8'h43, 1);
    expect_byte(8'hA3); expect_byte(8'h41); expect_byte(8'h42); expect_byte(8'h43);
    drive_src();
    wait_exp_left("t4_first_beat", 2, 50);
    stall[3] = 1'b1;
    beat(0, 8'h0A, 1);
    expect_byte(8'hA0); expect_byte(8'h0A);
    drive_src();
    saw_p0_ready = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("t4_grant_held", 32'(grant), 32'(3));
    chk("t4_busy_held", 32'(busy), 32'(1));
    chk("t4_p0_not_served", 32'(saw_p0_ready), 32'(0));
    stall[3] = 1'b0;
    drive_src();
    wait_done("t4_done", 80);
    chk("t4_p0_drained", 32'(src_q[0].size()), 32'(0));

    // 5: header-less instance, single-beat packet on port 1
    nh_s_valid = 4'b0010;
    nh_s_last  = 4'b0010;
    nh_s_data  = 32'h0000_5A00;
    chk("t5_idle_valid", 32'(nh_m_valid), 32'(0));
    chk("t5_idle_ready", 32'(nh_s_ready), 32'(0));
    tick();
    chk("t5_data", 32'(nh_m_data), 32'(8'h5A));
    chk("t5_valid", 32'(nh_m_valid), 32'(1));
    chk("t5_s_ready", 32'(nh_s_ready), 32'(4'b0010));
    chk("t5_grant", 32'(nh_grant), 32'(1));
    chk("t5_busy", 32'(nh_busy), 32'(1));
    tick();
    nh_s_valid = '0;
    nh_s_last  = '0;
    chk("t5_after_busy", 32'(nh_busy), 32'(0));
    chk("t5_after_ready", 32'(nh_s_ready), 32'(0));

    // 6: reset during a DATA beat of port 2
    beat(2, 8'h61, 0); beat(2, 8'h62, 1);
    expect_byte(8'hA2); expect_byte(8'h61); expect_byte(8'h62);
    drive_src();
    wait_exp_left("t6_header", 2, 50);
    chk("t6_in_data", 32'(m_valid), 32'(1));
    rst = 1'b1;
    tick();
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_m_valid", 32'(m_valid), 32'(0));
    chk("t6_rst_m_data", 32'(m_data), 32'(0));
    chk("t6_rst_s_ready", 32'(s_ready), 32'(0));
    chk("t6_rst_grant", 32'(grant), 32'(0));
    rst = 1'b0;
    exp_q.delete();
    src_q[2].delete();
    beat(3, 8'h71, 1);
    beat(0, 8'h07, 1);
    expect_byte(8'hA0); expect_byte(8'h07);
    expect_byte(8'hA3); expect_byte(8'h71);
    drive_src();
    wait_done("t6_done", 80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
